// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: OAM DMA state encoding and the
// register addresses the DMA engine snoops and targets.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage : nes_bus_pkg

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to TRIGGER_ADDR copies page $XX00-$XXFF
// to OAM_PORT one byte per read/write pair while holding the CPU paused.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = ADDR_OAMDMA,
  parameter logic [15:0] OAM_PORT     = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mw,
  input  logic [7:0]  mem_din,
  output logic        cpu_pause,
  output logic [15:0] dma_aout,
  output logic [7:0]  dma_dout,
  output logic        dma_mr,
  output logic        dma_mw,
  output logic        dma_done
);

  dma_state_t state_q, state_d;
  logic       odd_q;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    dma_aout  = 16'h0000;
    dma_dout  = buf_q;
    dma_mr    = 1'b0;
    dma_mw    = 1'b0;
    dma_done  = 1'b0;
    cpu_pause = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cpu_mw && (cpu_aout == TRIGGER_ADDR)) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      // odd_q=1 now means the following cycle is a get cycle, so READ may
      // start there; otherwise one ALIGN cycle pushes it onto even parity.
      HALT:  state_d = odd_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        dma_aout = {page_q, idx_q};
        dma_mr   = 1'b1;
        buf_d    = mem_din;
        state_d  = WRITE;
      end
      WRITE: begin
        dma_aout = OAM_PORT;
        dma_mw   = 1'b1;
        idx_d    = idx_q + 8'h01;
        if (idx_q == 8'hFF) begin
          dma_done = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      odd_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      buf_q   <= 8'h00;
    end else if (ce) begin
      state_q <= state_d;
      odd_q   <= ~odd_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule : oam_dma

// File: doc/oam_dma.md
# oam_dma

Sprite (OAM) DMA engine sitting directly beside the CPU on the system bus: it snoops CPU writes, and a write to $4014 starts a 256-byte copy from CPU page $XX00–$XXFF to the PPU OAM data port $2004. While copying it stalls the CPU through a pause output and drives the shared address and data bus in the CPU's place. The top level gates the CPU clock enable with `ce & ~cpu_pause` and muxes the bus onto the DMA outputs while `cpu_pause` is high.

## Interface
Parameters:
- `TRIGGER_ADDR`, default 16'h4014: CPU write address that starts a DMA.
- `OAM_PORT`, default 16'h2004: destination address for every DMA write.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: CPU-rate clock enable. All state advances only when `ce`=1.
- `cpu_aout` in 16: CPU address bus (snooped).
- `cpu_dout` in 8: CPU write data (snooped); supplies the page number.
- `cpu_mw` in 1: CPU write strobe (snooped).
- `mem_din` in 8: read data returned by the bus for DMA reads.
- `cpu_pause` out 1: high while the DMA owns the bus; stalls the CPU.
- `dma_aout` out 16: DMA address.
- `dma_dout` out 8: DMA write data.
- `dma_mr` out 1: DMA read strobe.
- `dma_mw` out 1: DMA write strobe.
- `dma_done` out 1: one `ce`-cycle pulse on the final write.

## Operation
- Parity flop `odd`: toggles on every `ce` and resets to 0. A cycle with `odd`=0 is a "get" cycle; a cycle with `odd`=1 is a "put" cycle.
- The FSM has five states: IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE: if `cpu_mw` and `cpu_aout`==`TRIGGER_ADDR`, latch `page`<=`cpu_dout`, `idx`<=0, and go to HALT.
  - HALT: one dummy cycle with no bus strobes. Next state is READ if the next cycle is a get cycle, otherwise ALIGN.
  - ALIGN: one dummy cycle, then READ.
  - READ: `dma_aout`={`page`,`idx`}, `dma_mr`=1. Latch `buf`<=`mem_din` at the end of the cycle, then go to WRITE.
  - WRITE: `dma_aout`=`OAM_PORT`, `dma_dout`=`buf`, `dma_mw`=1, `idx`<=`idx`+1 (8-bit, wraps). If `idx`==255, pulse `dma_done` and go to IDLE; otherwise go to READ.
- `cpu_pause`=1 in every state except IDLE. It is decoded from the registered state, so it has no combinational path from the inputs.
- In IDLE, HALT and ALIGN the bus outputs are `dma_mr`=0, `dma_mw`=0, `dma_aout`=0 and `dma_dout`=`buf`.
- Source addresses never cross the page boundary: `idx` wraps and the page stays fixed.
- A trigger write seen outside IDLE is ignored. This cannot occur while the CPU is paused, but the RTL must not depend on that.
- The page value is arbitrary; pages $00–$FF are all legal, including $40 (the I/O page).

## Timing
- Reset (async assert, deassert synchronous to `clk`): state=IDLE, `odd`=0, `page`=0, `idx`=0, `buf`=0. All outputs are 0.
- `reset_n` low during a transfer aborts it immediately: `cpu_pause` and the strobes drop asynchronously.
- With `ce`=0, all registers hold and the outputs remain constant.
- With the trigger write in `ce`-cycle N, HALT occupies cycle N+1. The first READ is at N+2 or N+3, chosen so that READ always lands on `odd`=0.
- The total pause is 513 `ce`-cycles if no ALIGN is needed, 514 with ALIGN.
- `dma_done` is high during the last WRITE cycle. `cpu_pause` falls at the first cycle after that WRITE.
- Read data is sampled at the same `ce` edge that ends the READ cycle (zero-wait memory).

## Structure
- Shared package `nes_bus_pkg`:
  - state enum `dma_state_t` (IDLE, HALT, ALIGN, READ, WRITE);
  - constants `ADDR_OAMDMA`=16'h4014 and `ADDR_OAMDATA`=16'h2004, which serve as the parameter defaults.
- The block is a single module with no sub-modules. The parity flop is kept internal; it is not shared with the APU frame counter.

## Test plan
- Trigger $4014←$02 on a cycle whose following cycle is even (HALT lands on an odd cycle), memory pattern mem[$02nn]=nn^$A5 → 256 writes to $2004 with data 00^A5…FF^A5 in order, 513 pause cycles, `dma_done` pulsed once.
- Same trigger one cycle later (HALT lands on an even cycle) → ALIGN inserted, 514 pause cycles, the first read addresses $0200 on an even cycle.
- `ce` toggled 1/0 randomly during the transfer → identical write sequence; the cycle count is measured in `ce`-cycles only.
- `reset_n` pulsed low at transfer byte 100 → `cpu_pause`=0 and strobes 0 immediately; after release the FSM stays IDLE until a new trigger.
- Page $FF with the source at $FF00–$FFFF → the last read is at $FFFF, there is no access to $0000, and `idx` returns to 0.
- CPU write to $4015 and a CPU read of $4014 → no DMA, `cpu_pause` stays 0.
